// File: rtl/whirlpool_wcipher_round_ctrl_if.sv
// Handshake and datapath bundle between the W-cipher round engine and its
// neighbours: block source, digest sink and the external gamma/pi/theta paths.
interface whirlpool_wcipher_round_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] msg_in;
    logic [511:0] hash_in;
    logic [511:0] s_out;
    logic [511:0] k_out;
    logic [511:0] th_s;
    logic [511:0] th_k;
    logic [3:0]   round;
    logic [63:0]  rc_in;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] digest_out;

    modport slave (
        input  in_valid, msg_in, hash_in, th_s, th_k, rc_in, out_ready,
        output in_ready, s_out, k_out, round, out_valid, digest_out
    );

    modport master (
        output in_valid, msg_in, hash_in, th_s, th_k, rc_in, out_ready,
        input  in_ready, s_out, k_out, round, out_valid, digest_out
    );
endinterface

// File: rtl/whirlpool_wcipher_round_ctrl.sv
// Whirlpool W-cipher round sequencer: holds state/key, folds in the external
// theta results plus round constant each cycle, then Miyaguchi-Preneel output.
module whirlpool_wcipher_round_ctrl #(
    parameter int ROUNDS       = 10,
    parameter bit FEED_FORWARD = 1'b1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    whirlpool_wcipher_round_ctrl_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [3:0] LAST_RND = 4'(ROUNDS);

    logic [1:0]   r_state;
    logic [3:0]   r_round;
    logic [511:0] r_s;
    logic [511:0] r_k;
    logic [511:0] r_msg;
    logic [511:0] r_hash;
    logic [511:0] r_digest;

    logic [511:0] w_knew;
    logic [511:0] w_snew;
    logic [511:0] w_final;

    // Only row 0 of the round constant is non-zero.
    assign w_knew  = bus.th_k ^ {bus.rc_in, 448'h0};
    assign w_snew  = bus.th_s ^ w_knew;
    assign w_final = FEED_FORWARD ? (w_snew ^ r_hash ^ r_msg) : w_snew;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_round  <= 4'd0;
            r_s      <= '0;
            r_k      <= '0;
            r_msg    <= '0;
            r_hash   <= '0;
            r_digest <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_k     <= bus.hash_in;
                        r_s     <= bus.msg_in ^ bus.hash_in;
                        r_msg   <= bus.msg_in;
                        r_hash  <= bus.hash_in;
                        r_round <= 4'd1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_k <= w_knew;
                    r_s <= w_snew;
                    if (r_round == LAST_RND) begin
                        r_round  <= 4'd0;
                        r_digest <= w_final;
                        r_state  <= ST_DONE;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                ST_DONE: begin
                    // Digest stays frozen until the sink takes it.
                    if (bus.out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == ST_IDLE);
    assign bus.out_valid  = (r_state == ST_DONE);
    assign bus.s_out      = r_s;
    assign bus.k_out      = r_k;
    assign bus.round      = r_round;
    assign bus.digest_out = r_digest;
endmodule
